// File: rtl/ula_pkg.sv
// Shared definitions for the iterative ALU: MIPS funct codes, FSM state
// encoding, operation-class helpers and the mult/div counter sizing function.
// The divide class is present only when ULA_DIV_EN is defined.
package ula_pkg;

    typedef logic [5:0] funct_t;

    localparam funct_t FUNCT_ADD   = 6'd32;
    localparam funct_t FUNCT_ADDU  = 6'd33;
    localparam funct_t FUNCT_SUB   = 6'd34;
    localparam funct_t FUNCT_SUBU  = 6'd35;
    localparam funct_t FUNCT_AND   = 6'd36;
    localparam funct_t FUNCT_OR    = 6'd37;
    localparam funct_t FUNCT_XOR   = 6'd38;
    localparam funct_t FUNCT_NOR   = 6'd39;
    localparam funct_t FUNCT_SLT   = 6'd42;
    localparam funct_t FUNCT_SLTU  = 6'd43;
    localparam funct_t FUNCT_MULT  = 6'd24;
    localparam funct_t FUNCT_MULTU = 6'd25;
    localparam funct_t FUNCT_DIV   = 6'd26;
    localparam funct_t FUNCT_DIVU  = 6'd27;

    // Handshake FSM state type and encodings.
    typedef logic [1:0] ula_state_t;
    localparam ula_state_t ST_IDLE   = 2'd0;
    localparam ula_state_t ST_MULDIV = 2'd1;
    localparam ula_state_t ST_DONE   = 2'd2;

`ifdef ULA_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    function automatic logic is_alu_op(input funct_t f);
        case (f)
            FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
            FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
            FUNCT_SLT, FUNCT_SLTU: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

    function automatic logic is_mul_op(input funct_t f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
    endfunction

    // Divide codes count as supported only when the divider is built.
    function automatic logic is_div_op(input funct_t f);
        return DIV_EN && ((f == FUNCT_DIV) || (f == FUNCT_DIVU));
    endfunction

    function automatic logic is_supported(input funct_t f);
        return is_alu_op(f) || is_mul_op(f) || is_div_op(f);
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_bits(input int n);
        int b;
        b = 1;
        while ((1 << b) < n) b++;
        return b;
    endfunction

endpackage

// File: rtl/ula_iterative_if.sv
// Request/response bus of the iterative ALU. The requester drives the
// operands and consumes the result through the master modport; the ALU
// sits on the slave modport.
interface ula_iterative_if #(
    parameter int WIDTH = 32
);
    import ula_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inputA;
    logic [WIDTH-1:0] inputB;
    funct_t           operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] outputLo;
    logic [WIDTH-1:0] outputHi;
    logic             div_by_zero;
    logic             illegal;

    modport master (
        output in_valid, inputA, inputB, operation, out_ready,
        input  in_ready, out_valid, outputLo, outputHi, div_by_zero, illegal
    );

    modport slave (
        input  in_valid, inputA, inputB, operation, out_ready,
        output in_ready, out_valid, outputLo, outputHi, div_by_zero, illegal
    );

endinterface

// File: rtl/ula_muldiv_iter.sv
// Iterative multiply/divide engine. Signed operands are reduced to
// magnitudes at start, MD_STEPS unsigned iterations run (shift-add multiply
// or restoring divide), and the sign is reapplied on the way out. done is
// high during the last iteration and res_hi/res_lo then carry the final,
// sign-corrected result so the caller can register it on that same edge.
// The divide datapath exists only when ULA_DIV_EN is defined.
module ula_muldiv_iter
    import ula_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MD_STEPS = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
`ifdef ULA_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int                CNT_W     = cnt_bits(MD_STEPS);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(MD_STEPS - 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;     // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;     // multiplier bits / quotient bits
    logic [WIDTH-1:0] oper_q, oper_d;         // multiplicand / divisor magnitude
    logic             neg_res_q, neg_res_d;   // negate product or quotient
`ifdef ULA_DIV_EN
    logic             is_div_q, is_div_d;
    logic             neg_rem_q, neg_rem_d;   // remainder follows dividend sign
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
`endif

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = is_signed && op_a[WIDTH-1];
    assign b_neg = is_signed && op_b[WIDTH-1];
    assign mag_a = a_neg ? (WIDTH'(0) - op_a) : op_a;
    assign mag_b = b_neg ? (WIDTH'(0) - op_b) : op_b;
    assign done  = busy_q && (count_q == LAST_STEP);

    // One iteration of the datapath: shift-add for multiply, restoring step for divide.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, oper_q} : '0);
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef ULA_DIV_EN
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, oper_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Sign correction of the value the final iteration produces.
    always_comb begin
        prod = {step_hi, step_lo};
        if (neg_res_q) prod = (2 * WIDTH)'(0) - prod;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef ULA_DIV_EN
        if (is_div_q) begin
            res_lo = neg_res_q ? (WIDTH'(0) - step_lo) : step_lo;
            res_hi = neg_rem_q ? (WIDTH'(0) - step_hi) : step_hi;
        end
`endif
    end

    // Next state: load magnitudes on start, iterate while busy, stop after the last step.
    always_comb begin
        busy_d    = busy_q;
        count_d   = count_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        oper_d    = oper_q;
        neg_res_d = neg_res_q;
`ifdef ULA_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
`endif
        if (start) begin
            busy_d    = 1'b1;
            count_d   = '0;
            acc_hi_d  = '0;
            acc_lo_d  = mag_a;
            oper_d    = mag_b;
            neg_res_d = a_neg ^ b_neg;
`ifdef ULA_DIV_EN
            is_div_d  = is_div;
            neg_rem_d = a_neg;
`endif
        end else if (busy_q) begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            if (done) begin
                busy_d  = 1'b0;
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Engine registers; a synchronous reset abandons any run in progress.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of block order.
        if (reset) begin
            busy_q    <= 1'b0;
            count_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            oper_q    <= '0;
            neg_res_q <= 1'b0;
`ifdef ULA_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            busy_q    <= busy_d;
            count_q   <= count_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            oper_q    <= oper_d;
            neg_res_q <= neg_res_d;
`ifdef ULA_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

endmodule

// File: rtl/ula_iterative.sv
// Iterative MIPS-style ALU with valid/ready handshake on both sides.
// Single-cycle ops (add..sltu), illegal funct codes and divide-by-zero
// finish one cycle after acceptance; mult/div run WIDTH iterations in
// ula_muldiv_iter. Results are held in DONE until the consumer takes them,
// and a new request may be accepted in that same cycle.
// Build option: define ULA_DIV_EN to include div/divu; otherwise funct 26/27
// report illegal and div_by_zero is always 0.
module ula_iterative
    import ula_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MD_STEPS = WIDTH   // must equal WIDTH in this generation
) (
    input  logic           clock,
    input  logic           reset,
    ula_iterative_if.slave bus
);

    ula_state_t       state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;

    logic             in_ready;
    logic             accept;
    logic             op_ok, op_mul, op_div, op_signed;
    logic [WIDTH-1:0] alu_res;
    logic             md_start, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign op_ok     = is_supported(bus.operation);
    assign op_mul    = is_mul_op(bus.operation);
    assign op_div    = is_div_op(bus.operation);
    assign op_signed = (bus.operation == FUNCT_MULT) || (bus.operation == FUNCT_DIV);

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state_q == ST_DONE);
    assign bus.outputLo    = lo_q;
    assign bus.outputHi    = hi_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.illegal     = ill_q;

    // Single-cycle ALU on the live request; its result is registered on acceptance.
    always_comb begin
        alu_res = '0;
        case (bus.operation)
            FUNCT_ADD, FUNCT_ADDU: alu_res = bus.inputA + bus.inputB;
            FUNCT_SUB, FUNCT_SUBU: alu_res = bus.inputA - bus.inputB;
            FUNCT_AND:             alu_res = bus.inputA & bus.inputB;
            FUNCT_OR:              alu_res = bus.inputA | bus.inputB;
            FUNCT_XOR:             alu_res = bus.inputA ^ bus.inputB;
            FUNCT_NOR:             alu_res = ~(bus.inputA | bus.inputB);
            FUNCT_SLT:             alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.inputA) < $signed(bus.inputB)};
            FUNCT_SLTU:            alu_res = {{(WIDTH-1){1'b0}}, bus.inputA < bus.inputB};
            default:               alu_res = '0;
        endcase
    end

    // Handshake FSM: retire the current state first, then let an acceptance override it.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        dbz_d    = dbz_q;
        ill_d    = ill_q;
        md_start = 1'b0;

        case (state_q)
            ST_MULDIV: begin
                if (md_done) begin
                    state_d = ST_DONE;
                    lo_d    = md_lo;
                    hi_d    = md_hi;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            dbz_d = 1'b0;
            ill_d = 1'b0;
            if (!op_ok) begin
                state_d = ST_DONE;
                lo_d    = '0;
                hi_d    = '0;
                ill_d   = 1'b1;
            end else if (op_div && (bus.inputB == '0)) begin
                state_d = ST_DONE;
                lo_d    = '1;
                hi_d    = bus.inputA;
                dbz_d   = 1'b1;
            end else if (op_mul || op_div) begin
                state_d  = ST_MULDIV;
                md_start = 1'b1;
            end else begin
                state_d = ST_DONE;
                lo_d    = alu_res;
                hi_d    = '0;
            end
        end
    end

    // Control and result registers; reset discards any pending or presented result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            dbz_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dbz_q   <= dbz_d;
            ill_q   <= ill_d;
        end
    end

    ula_muldiv_iter #(
        .WIDTH    (WIDTH),
        .MD_STEPS (MD_STEPS)
    ) u_muldiv (
        .clock     (clock),
        .reset     (reset),
        .start     (md_start),
        .is_signed (op_signed),
`ifdef ULA_DIV_EN
        .is_div    (op_div),
`endif
        .op_a      (bus.inputA),
        .op_b      (bus.inputB),
        .done      (md_done),
        .res_hi    (md_hi),
        .res_lo    (md_lo)
    );

endmodule

// File: tb/tb_ula_iterative.sv
// Bench for ula_iterative (WIDTH=32): arithmetic reference model plus
// directed vectors with hand-computed results, back-pressure and abort cases.
module tb_ula_iterative;

    localparam int W = 32;

    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_XOR   = 6'd38;
    localparam logic [5:0] F_NOR   = 6'd39;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SLTU  = 6'd43;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
`ifdef ULA_DIV_EN
    localparam logic [5:0] F_ABORT = F_DIVU;
`else
    localparam logic [5:0] F_ABORT = F_MULTU;
`endif

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        logic         ill;
        int           lat;
    } exp_t;

    typedef struct {
        exp_t e;
        int   due;
    } pend_t;

    logic   clock = 1'b0;
    logic   reset = 1'b1;
    int     cyc    = 0;
    int     checks = 0;
    int     errors = 0;
    pend_t  pend[$];
    bit     front_seen = 1'b0;

    ula_iterative_if #(.WIDTH(W)) bus ();

    ula_iterative #(.WIDTH(W), .MD_STEPS(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what the result must be, from plain arithmetic on the operands.
    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sb, sp;
        logic [63:0] up;
        e.lo = '0; e.hi = '0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            6'd32, 6'd33: e.lo = a + b;
            6'd34, 6'd35: e.lo = a - b;
            6'd36: e.lo = a & b;
            6'd37: e.lo = a | b;
            6'd38: e.lo = a ^ b;
            6'd39: e.lo = ~(a | b);
            6'd42: e.lo = (sa < sb) ? 32'd1 : 32'd0;
            6'd43: e.lo = (a < b) ? 32'd1 : 32'd0;
            6'd24: begin sp = sa * sb; {e.hi, e.lo} = sp; e.lat = W + 1; end
            6'd25: begin up = {32'd0, a} * {32'd0, b}; {e.hi, e.lo} = up; e.lat = W + 1; end
`ifdef ULA_DIV_EN
            6'd26, 6'd27: begin
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.dbz = 1'b1;
                end else if (f == 6'd26) begin
                    sp = sa / sb; e.lo = sp[W-1:0];
                    sp = sa % sb; e.hi = sp[W-1:0];
                    e.lat = W + 1;
                end else begin
                    e.lo = a / b; e.hi = a % b; e.lat = W + 1;
                end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Compare process: every cycle out_valid is high, the DUT must show the model's answer.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                pend.delete();
                front_seen = 1'b0;
            end else begin
                if (bus.out_valid) begin
                    if (pend.size() == 0) begin
                        check("out_valid_unexpected", bus.out_valid, 1'b0);
                    end else begin
                        if (!front_seen) begin
                            check("latency", cyc, pend[0].due);
                            front_seen = 1'b1;
                        end
                        check("model_lo",  bus.outputLo,    pend[0].e.lo);
                        check("model_hi",  bus.outputHi,    pend[0].e.hi);
                        check("model_dbz", bus.div_by_zero, pend[0].e.dbz);
                        check("model_ill", bus.illegal,     pend[0].e.ill);
                        if (bus.out_ready) begin
                            void'(pend.pop_front());
                            front_seen = 1'b0;
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    e = model(bus.operation, bus.inputA, bus.inputB);
                    pend.push_back('{e: e, due: cyc + e.lat});
                end
            end
        end
    end

    // Offer a request until accepted, then scramble the inputs to prove they were captured.
    task automatic send(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        @(posedge clock); #1;
        bus.in_valid  = 1'b1;
        bus.operation = f;
        bus.inputA    = a;
        bus.inputB    = b;
        forever begin
            @(negedge clock);
            if (bus.in_ready) break;
            n++;
            if (n > 100) begin
                check("accept_timeout", bus.in_ready, 1'b1);
                break;
            end
        end
        @(posedge clock); #1;
        bus.in_valid  = 1'b0;
        bus.operation = 6'($urandom);
        bus.inputA    = $urandom;
        bus.inputB    = $urandom;
    endtask

    task automatic wait_result(input string name, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            n++;
            if (n > 100) begin
                check({name, "_timeout"}, bus.out_valid, 1'b1);
                break;
            end
        end
    endtask

    task automatic run(input string name, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                       input logic exp_dbz, input logic exp_ill);
        bit ok;
        send(f, a, b);
        wait_result(name, ok);
        if (ok) begin
            check({name, "_lo"},  bus.outputLo,    exp_lo);
            check({name, "_hi"},  bus.outputHi,    exp_hi);
            check({name, "_dbz"}, bus.div_by_zero, exp_dbz);
            check({name, "_ill"}, bus.illegal,     exp_ill);
        end
    endtask

    logic [5:0] rnd_ops [9] = '{F_ADD, F_SUB, F_SLT, F_SLTU, F_NOR, F_MULT, F_MULTU, F_DIV, F_DIVU};

    initial begin : stimulus
        bit ok;
        bit seen_valid;
        bus.in_valid  = 1'b0;
        bus.inputA    = '0;
        bus.inputB    = '0;
        bus.operation = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_out_valid", bus.out_valid,   1'b0);
        check("rst_in_ready",  bus.in_ready,    1'b1);
        check("rst_lo",        bus.outputLo,    32'd0);
        check("rst_hi",        bus.outputHi,    32'd0);
        check("rst_dbz",       bus.div_by_zero, 1'b0);
        check("rst_ill",       bus.illegal,     1'b0);

        // Single-cycle class.
        run("add_ovf",   F_ADD,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 32'd0, 1'b0, 1'b0);
        run("sub_0_1",   F_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        run("and",       F_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'd0, 1'b0, 1'b0);
        run("or",        F_OR,   32'hF000_000F, 32'h0000_F0F0, 32'hF000_F0FF, 32'd0, 1'b0, 1'b0);
        run("xor",       F_XOR,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 32'd0, 1'b0, 1'b0);
        run("nor",       F_NOR,  32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        run("slt_neg",   F_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         32'd0, 1'b0, 1'b0);
        run("sltu_big",  F_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0, 1'b0, 1'b0);
        run("illegal3f", 6'h3F,  32'd5,         32'd6,         32'd0,         32'd0, 1'b0, 1'b1);

        // Multiply.
        run("mult_m3_5",  F_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run("multu_ff_2", F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1,         1'b0, 1'b0);

        // Divide.
`ifdef ULA_DIV_EN
        run("div_m7_2",     F_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run("div_7_m2",     F_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0);
        run("div_min_m1",   F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1'b0);
        run("divu_9_0",     F_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 32'd9,         1'b1, 1'b0);
        run("divu_100_7",   F_DIVU, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0);
`else
        run("div_disabled",  F_DIV,  32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b1);
        run("divu_disabled", F_DIVU, 32'd9,         32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
`endif

        // Model-only mix with random operands.
        for (int i = 0; i < 9; i++) begin
            send(rnd_ops[i], $urandom, (i == 8) ? 32'd0 : $urandom);
            wait_result("rnd", ok);
        end

        // Back-pressure: result held, no new acceptance, then zero-bubble handover.
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        run("bp_mult", F_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        repeat (10) begin
            @(negedge clock);
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_lo_stable", bus.outputLo,  32'hFFFF_FFF1);
            check("bp_in_ready",  bus.in_ready,  1'b0);
        end
        @(posedge clock); #1;
        bus.in_valid  = 1'b1;
        bus.operation = F_ADD;
        bus.inputA    = 32'h10;
        bus.inputB    = 32'h20;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("handover_in_ready", bus.in_ready, 1'b1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("handover_out_valid", bus.out_valid, 1'b1);
        check("handover_lo",        bus.outputLo,  32'h30);

        // Abort: reset during the tenth iteration discards the run.
        send(F_ABORT, 32'd1000, 32'd7);
        repeat (9) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("abort_in_ready", bus.in_ready, 1'b1);
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("abort_no_result", seen_valid, 1'b0);
        run("add_after_reset", F_ADD, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0);

        repeat (5) @(negedge clock);
        check("queue_drained", pend.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
